// File: rtl/access_pkg.sv
// Shared types and sizing helpers for the multi-door access controller.
package access_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_e;

    localparam logic [16:0] MASTER_KEY_DEFAULT = 17'd45675;

    // One timer serves both the unlock and the lockout countdown.
    function automatic int timer_width(input int unlock_cyc, input int lockout_cyc);
        int m;
        m = (unlock_cyc > lockout_cyc) ? unlock_cyc : lockout_cyc;
        return $clog2(m);
    endfunction

    function automatic int fail_width(input int max_tries);
        return (max_tries < 2) ? 1 : $clog2(max_tries);
    endfunction

endpackage

// File: rtl/access_channel.sv
// One door channel: edge detect, password register, fail counter, timer and FSM.
module access_channel
    import access_pkg::*;
#(
    parameter int              PW_W        = 17,
    parameter int              MAX_TRIES   = 3,
    parameter int              UNLOCK_CYC  = 500,
    parameter int              LOCKOUT_CYC = 1000,
    parameter logic [PW_W-1:0] DEFAULT_PW  = '0,
    parameter logic [PW_W-1:0] MASTER_KEY  = PW_W'(MASTER_KEY_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enter,
    input  logic            chg,
    input  logic [PW_W-1:0] pw_in,
    input  logic [PW_W-1:0] pw_new,
    input  logic            alarm_clr,
    output logic            locked,
    output logic            lockout,
    output logic            alarm,
    output logic            accept,
    output logic            reject
);

    localparam int TW = timer_width(UNLOCK_CYC, LOCKOUT_CYC);
    localparam int FW = fail_width(MAX_TRIES);
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic            enter_q;
    logic            alarm_q, alarm_d;
    logic            accept_q, accept_d;
    logic            reject_q, reject_d;

    logic ev, match, is_master, timer_zero;

    assign ev         = enter & ~enter_q;
    assign is_master  = (pw_in == MASTER_KEY);
    assign match      = (pw_in == pw_q) | is_master;
    assign timer_zero = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_zero ? '0 : timer_q - TW'(1);
        fail_d   = fail_q;
        pw_d     = pw_q;
        alarm_d  = alarm_q;
        accept_d = 1'b0;
        reject_d = 1'b0;

        // Acknowledge first so a lockout entry in the same cycle re-asserts alarm.
        if (alarm_clr && state_q != ST_LOCKOUT) alarm_d = 1'b0;

        unique case (state_q)
            ST_LOCKOUT: begin
                if (ev && !chg && is_master) begin
                    state_d  = ST_LOCKED;
                    alarm_d  = 1'b0;
                    accept_d = 1'b1;
                end else if (timer_zero) begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                if (state_q == ST_UNLOCKED && timer_zero && !ev) state_d = ST_LOCKED;
                if (ev) begin
                    if (match) begin
                        if (!chg) begin
                            state_d  = ST_UNLOCKED;
                            timer_d  = UNLOCK_LOAD;
                            fail_d   = '0;
                            accept_d = 1'b1;
                        end else if (pw_new != '0) begin
                            pw_d     = pw_new;
                            fail_d   = '0;
                            accept_d = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else begin
                        reject_d = 1'b1;
                        if (int'(fail_q) + 1 == MAX_TRIES) begin
                            state_d = ST_LOCKOUT;
                            alarm_d = 1'b1;
                            timer_d = LOCKOUT_LOAD;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_q + FW'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOCKED;
            timer_q  <= '0;
            fail_q   <= '0;
            pw_q     <= DEFAULT_PW;
            enter_q  <= 1'b0;
            alarm_q  <= 1'b0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            fail_q   <= fail_d;
            pw_q     <= pw_d;
            enter_q  <= enter;
            alarm_q  <= alarm_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
        end
    end

    assign locked  = (state_q != ST_UNLOCKED);
    assign lockout = (state_q == ST_LOCKOUT);
    assign alarm   = alarm_q;
    assign accept  = accept_q;
    assign reject  = reject_q;

endmodule

// File: rtl/access_controller.sv
// Multi-door keypad access controller: unpacks buses and replicates access_channel.
module access_controller
    import access_pkg::*;
#(
    parameter int              N_DOORS     = 4,
    parameter int              PW_W        = 17,
    parameter int              MAX_TRIES   = 3,
    parameter int              UNLOCK_CYC  = 500,
    parameter int              LOCKOUT_CYC = 1000,
    parameter logic [PW_W-1:0] DEFAULT_PW  = '0,
    parameter logic [PW_W-1:0] MASTER_KEY  = PW_W'(MASTER_KEY_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_DOORS-1:0]      enter,
    input  logic [N_DOORS-1:0]      chg,
    input  logic [N_DOORS*PW_W-1:0] pw_in,
    input  logic [N_DOORS*PW_W-1:0] pw_new,
    input  logic [N_DOORS-1:0]      alarm_clr,
    output logic [N_DOORS-1:0]      locked,
    output logic [N_DOORS-1:0]      lockout,
    output logic [N_DOORS-1:0]      alarm,
    output logic [N_DOORS-1:0]      accept,
    output logic [N_DOORS-1:0]      reject
);

    for (genvar gi = 0; gi < N_DOORS; gi++) begin : g_ch
        access_channel #(
            .PW_W        (PW_W),
            .MAX_TRIES   (MAX_TRIES),
            .UNLOCK_CYC  (UNLOCK_CYC),
            .LOCKOUT_CYC (LOCKOUT_CYC),
            .DEFAULT_PW  (DEFAULT_PW),
            .MASTER_KEY  (MASTER_KEY)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enter     (enter[gi]),
            .chg       (chg[gi]),
            .pw_in     (pw_in[gi*PW_W +: PW_W]),
            .pw_new    (pw_new[gi*PW_W +: PW_W]),
            .alarm_clr (alarm_clr[gi]),
            .locked    (locked[gi]),
            .lockout   (lockout[gi]),
            .alarm     (alarm[gi]),
            .accept    (accept[gi]),
            .reject    (reject[gi])
        );
    end

endmodule

// File: tb/tb_access_controller.sv
// Bench for access_controller: deadline-based reference model checked every cycle plus directed literal checks.
module tb_access_controller;

    localparam int N  = 2;
    localparam int W  = 17;
    localparam int MT = 3;
    localparam int UC = 8;
    localparam int LC = 16;
    localparam logic [W-1:0] DEF = 17'd1234;
    localparam logic [W-1:0] MK  = 17'd45675;
    localparam int M_LOCKED = 0, M_OPEN = 1, M_OUT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   enter = '0, chg = '0, alarm_clr = '0;
    logic [N*W-1:0] pw_in = '0, pw_new = '0;
    logic [N-1:0]   locked, lockout, alarm, accept, reject;

    int errors = 0;
    int checks = 0;

    access_controller #(
        .N_DOORS     (N),
        .PW_W        (W),
        .MAX_TRIES   (MT),
        .UNLOCK_CYC  (UC),
        .LOCKOUT_CYC (LC),
        .DEFAULT_PW  (DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enter     (enter),
        .chg       (chg),
        .pw_in     (pw_in),
        .pw_new    (pw_new),
        .alarm_clr (alarm_clr),
        .locked    (locked),
        .lockout   (lockout),
        .alarm     (alarm),
        .accept    (accept),
        .reject    (reject)
    );

    always #5 clk = ~clk;

    // Reference model: door state plus absolute deadlines (edge indices).
    int          cyc = 0;
    bit          m_valid = 1'b0;
    int          m_mode[N];
    int          m_open_end[N];
    int          m_lo_end[N];
    logic [W-1:0] m_pw[N];
    int          m_fail[N];
    bit          m_alarm[N], m_acc[N], m_rej[N], m_prev[N];

    task automatic model_step();
        bit ev;
        logic [W-1:0] p, n;
        cyc++;
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 1'b0;
            m_rej[i] = 1'b0;
            if (rst) begin
                m_mode[i] = M_LOCKED; m_pw[i] = DEF; m_fail[i] = 0;
                m_alarm[i] = 1'b0; m_prev[i] = 1'b0;
                m_open_end[i] = 0; m_lo_end[i] = 0;
                m_valid = 1'b1;
            end else begin
                ev = enter[i] && !m_prev[i];
                m_prev[i] = enter[i];
                p = pw_in[i*W +: W];
                n = pw_new[i*W +: W];
                if (alarm_clr[i] && m_mode[i] != M_OUT) m_alarm[i] = 1'b0;
                if (m_mode[i] == M_OUT) begin
                    if (ev && !chg[i] && p == MK) begin
                        m_mode[i] = M_LOCKED; m_alarm[i] = 1'b0; m_acc[i] = 1'b1;
                    end else if (cyc >= m_lo_end[i]) begin
                        m_mode[i] = M_LOCKED;
                    end
                end else if (ev) begin
                    if (p == m_pw[i] || p == MK) begin
                        if (!chg[i]) begin
                            m_mode[i] = M_OPEN; m_open_end[i] = cyc + UC;
                            m_fail[i] = 0; m_acc[i] = 1'b1;
                        end else if (n != 0) begin
                            m_pw[i] = n; m_fail[i] = 0; m_acc[i] = 1'b1;
                        end else begin
                            m_rej[i] = 1'b1;
                        end
                    end else begin
                        m_rej[i] = 1'b1;
                        m_fail[i]++;
                        if (m_fail[i] == MT) begin
                            m_mode[i] = M_OUT; m_lo_end[i] = cyc + LC;
                            m_alarm[i] = 1'b1; m_fail[i] = 0;
                        end
                    end
                end else if (m_mode[i] == M_OPEN && cyc >= m_open_end[i]) begin
                    m_mode[i] = M_LOCKED;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            for (int i = 0; i < N; i++) begin
                logic [4:0] act, exp;
                act = {locked[i], lockout[i], alarm[i], accept[i], reject[i]};
                exp = {m_mode[i] != M_OPEN, m_mode[i] == M_OUT, m_alarm[i], m_acc[i], m_rej[i]};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL model ch%0d cyc=%0d {locked,lockout,alarm,accept,reject} got=%b exp=%b",
                             i, cyc, act, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves one low-enter edge, then one edge with enter high; returns just after the event edge.
    task automatic press(input int ch, input logic [W-1:0] p, input logic c, input logic [W-1:0] nw);
        @(negedge clk);
        pw_in[ch*W +: W]  = p;
        pw_new[ch*W +: W] = nw;
        chg[ch]   = c;
        enter[ch] = 1'b1;
        @(negedge clk);
        enter[ch] = 1'b0;
        chg[ch]   = 1'b0;
    endtask

    initial begin
        int cnt;
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("reset_locked", int'(locked), 3);
        chk("reset_lockout", int'(lockout), 0);
        chk("reset_alarm", int'(alarm), 0);

        // Basic unlock and auto-relock after 8 cycles
        press(0, DEF, 1'b0, '0);
        chk("unlock_accept", int'(accept[0]), 1);
        chk("unlock_open", int'(locked[0]), 0);
        chk("unlock_ch1_locked", int'(locked[1]), 1);
        tick(7);
        chk("open_last_cycle", int'(locked[0]), 0);
        tick(1);
        chk("auto_relock", int'(locked[0]), 1);

        // Three failures on channel 1 -> lockout
        for (int k = 0; k < 3; k++) begin
            press(1, 17'd999, 1'b0, '0);
            chk("bad_reject", int'(reject[1]), 1);
        end
        chk("lockout_set", int'(lockout[1]), 1);
        chk("alarm_set", int'(alarm[1]), 1);
        press(1, DEF, 1'b0, '0);
        chk("lockout_ignore_acc", int'(accept[1]), 0);
        chk("lockout_ignore_rej", int'(reject[1]), 0);
        tick(13);
        chk("lockout_held", int'(lockout[1]), 1);
        tick(1);
        chk("lockout_expired", int'(lockout[1]), 0);
        chk("alarm_sticky", int'(alarm[1]), 1);
        alarm_clr[1] = 1'b1;
        tick(1);
        alarm_clr[1] = 1'b0;
        chk("alarm_cleared", int'(alarm[1]), 0);

        // Password change on channel 0
        press(0, DEF, 1'b1, 17'd4321);
        chk("chg_accept", int'(accept[0]), 1);
        chk("chg_still_locked", int'(locked[0]), 1);
        press(0, DEF, 1'b0, '0);
        chk("old_pw_reject", int'(reject[0]), 1);
        press(0, 17'd4321, 1'b0, '0);
        chk("new_pw_accept", int'(accept[0]), 1);
        chk("new_pw_open", int'(locked[0]), 0);
        press(0, 17'd4321, 1'b1, 17'd0);
        chk("zero_pw_reject", int'(reject[0]), 1);
        tick(10);
        press(0, 17'd4321, 1'b0, '0);
        chk("pw_kept_accept", int'(accept[0]), 1);
        tick(10);

        // Master key exit from lockout
        for (int k = 0; k < 3; k++) press(1, 17'd5, 1'b0, '0);
        chk("lockout2_set", int'(lockout[1]), 1);
        press(1, MK, 1'b0, '0);
        chk("master_accept", int'(accept[1]), 1);
        chk("master_lockout_clr", int'(lockout[1]), 0);
        chk("master_alarm_clr", int'(alarm[1]), 0);
        chk("master_locked", int'(locked[1]), 1);

        // Enter held high for 20 cycles gives a single accept
        @(negedge clk);
        pw_in[0 +: W] = 17'd4321;
        enter[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (accept[0]) cnt++;
        end
        enter[0] = 1'b0;
        chk("held_one_accept", cnt, 1);

        // Re-entry exactly at timer 0 keeps the door open for 8 more cycles
        press(0, 17'd4321, 1'b0, '0);
        tick(6);
        press(0, 17'd4321, 1'b0, '0);
        chk("reentry_accept", int'(accept[0]), 1);
        chk("reentry_open", int'(locked[0]), 0);
        tick(7);
        chk("reentry_still_open", int'(locked[0]), 0);
        tick(1);
        chk("reentry_relock", int'(locked[0]), 1);

        // Reset mid-operation
        press(0, 17'd4321, 1'b0, '0);
        for (int k = 0; k < 3; k++) press(1, 17'd7, 1'b0, '0);
        chk("pre_rst_open", int'(locked[0]), 0);
        chk("pre_rst_lockout", int'(lockout[1]), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_locked", int'(locked), 3);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_alarm", int'(alarm), 0);
        press(0, DEF, 1'b0, '0);
        chk("rst_pw_restored", int'(accept[0]), 1);
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
